mw_sequencer: RTL and testbench
===============================

MW_SEQUENCER -- requirements
Module: mw_sequencer

Interface
REQ-001 SHALL have a single clock domain; reset is asynchronous and active-low.
REQ-002 SHALL provide port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL provide port clearn  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port tick  input  1  one-cycle 1 Hz countdown strobe.
REQ-005 SHALL provide port keypad  input  10  one-hot digit keys; bit k = digit k.
REQ-006 SHALL provide port startn  input  1  start button, active-low.
REQ-007 SHALL provide port stopn  input  1  stop button, active-low.
REQ-008 SHALL provide port door_closed  input  1  door interlock; 1 = closed.
REQ-009 SHALL provide ports min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD time, MM:SS.
REQ-010 SHALL provide port mag_on  output  1  magnetron enable.
REQ-011 SHALL provide port done  output  1  high while in DONE.
REQ-012 SHALL provide port state  output  2  IDLE=0, COOK=1, PAUSE=2, DONE=3.

Function
REQ-013 SHALL accept a key press only when keypad was all-zero last cycle and has exactly one bit set this cycle; multi-bit patterns are ignored.
REQ-014 SHALL, on an accepted key in IDLE only, shift the time left one digit (min_tens<-min_ones<-sec_tens<-sec_ones<-key) on the next edge; keys in other states are ignored.
REQ-015 SHALL detect a start event as a 1->0 transition of startn between consecutive edges; a held-low startn yields one event.
REQ-016 SHALL go IDLE->COOK on a start event when door_closed=1 and time is nonzero; a start event with door_closed=0 is ignored.
REQ-017 SHALL, in COOK, on tick, decrement the time as BCD: sec_ones 0->9 with borrow, sec_tens 0->5 with borrow, min_ones 0->9 with borrow, min_tens minus 1.
REQ-018 SHALL, when a COOK decrement yields 00:00, enter DONE on that same edge.
REQ-019 SHALL, in COOK, go to PAUSE when door_closed=0 or stopn=0, without decrementing.
REQ-020 SHALL, in PAUSE, ignore tick, hold the time, and go to COOK on a start event with door_closed=1.
REQ-021 SHALL, in PAUSE, go to IDLE with time cleared to 00:00 when stopn=0.
REQ-022 SHALL, in IDLE, clear the time to 00:00 when stopn=0.
REQ-023 SHALL, in DONE, go to IDLE with time 00:00 on stopn=0 or door_closed=0.
REQ-024 SHALL drive mag_on = (state==COOK) AND door_closed combinationally, so the magnetron drops in the same cycle the door opens.
REQ-025 SHALL, when stopn=0 coincides with a start event, act on stop only.
REQ-026 SHALL, when tick coincides with door opening or stop, apply no decrement.
REQ-027 SHALL decrement entered digits exceeding BCD range (e.g. sec_tens=7) without clamping; only the borrow reload values are fixed.

Reset
REQ-028 SHALL, while clearn=0, force state=IDLE, all time digits=0, done=0 and mag_on=0.
REQ-029 SHALL, while clearn=0, set the startn history to 1 and the keypad history to 0.
REQ-030 SHALL, when clearn asserts mid-COOK, drop mag_on immediately and lose the remaining time.

Configuration
REQ-031 SHALL implement macro QUICK_START_EN: when defined, a start event in IDLE with time 00:00 and door closed loads 00:30 and enters COOK on the same edge.
REQ-032 SHALL, when QUICK_START_EN is not defined, ignore a start event in IDLE with time 00:00.

Verification
REQ-033 SHALL cover: reset, keys 2 then 0, start, 20 ticks -> time 00:20 counts to 00:00; DONE on the 20th tick; mag_on high throughout.
REQ-034 SHALL cover: keys 1,0,0 (01:00), start, 1 tick -> 00:59; keys pressed in COOK leave the time unchanged.
REQ-035 SHALL cover: COOK at 00:15, door_closed=0 with a simultaneous tick -> PAUSE at 00:15, mag_on 0 that cycle; door closed plus start -> COOK resumes from 00:15.
REQ-036 SHALL cover: PAUSE with stopn=0 -> IDLE at 00:00; stopn=0 together with a start edge in IDLE -> stays IDLE.
REQ-037 SHALL cover: keypad=0000000011 -> ignored; startn held low for 500 cycles -> exactly one start event.
REQ-038 SHALL cover: QUICK_START_EN defined, start at 00:00 -> COOK at 00:30; not defined -> stays IDLE.

Source files
------------

// File: rtl/mw_sequencer.sv
// -----------------------------------------------------------------------------
// mw_sequencer -- microwave oven controller.
//
// Collects up to four keypad digits into an MM:SS BCD time, counts the time
// down on a 1 Hz strobe while cooking, and handles pause / resume / stop and
// the door interlock. The magnetron enable is gated combinationally by the
// door so it drops in the same cycle the door opens.
//
// Optional feature (macro QUICK_START_EN):
//   defined     -> a start event in IDLE with time 00:00 and the door closed
//                  loads 00:30 and begins cooking on the same edge.
//   not defined -> a start event in IDLE with time 00:00 is ignored.
// -----------------------------------------------------------------------------
module mw_sequencer (
    input  logic       clk,
    input  logic       clearn,
    input  logic       tick,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Time is held as four packed BCD digits: {min_tens, min_ones, sec_tens, sec_ones}.
    localparam logic [15:0] TIME_ZERO  = 16'h0000;
    localparam logic [15:0] TIME_QUICK = 16'h0030;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_time;
    logic [15:0] w_time_next;
    logic [9:0]  r_keypad_prev;
    logic        r_startn_prev;

    logic        w_key_onehot;
    logic        w_key_accept;
    logic [3:0]  w_key_digit;
    logic        w_start_event;
    logic        w_stop;
    logic        w_time_zero;
    logic [15:0] w_time_shift;
    logic [15:0] w_time_dec;
    logic        w_dec_zero;

    // -------------------------------------------------------------------------
    // Input qualification
    // -------------------------------------------------------------------------

    // A key counts only on a clean press: nothing held last cycle, exactly one
    // key this cycle. Chords and held keys are ignored.
    assign w_key_onehot  = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    assign w_key_accept  = w_key_onehot && (r_keypad_prev == 10'd0);

    // Falling edge of the active-low start button; holding it yields one event.
    assign w_start_event = r_startn_prev & ~startn;
    assign w_stop        = ~stopn;

    // Encode the pressed key into its digit value.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        w_key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) begin
                w_key_digit = 4'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Time arithmetic
    // -------------------------------------------------------------------------

    assign w_time_zero  = (r_time == TIME_ZERO);
    assign w_time_shift = {r_time[11:0], w_key_digit};

    // BCD countdown by one second. Only the borrow reload values are fixed;
    // a digit entered above its normal range simply counts down from there.
    always_comb begin
        w_time_dec = r_time;
        if (r_time[3:0] != 4'd0) begin
            w_time_dec[3:0] = r_time[3:0] - 4'd1;
        end else begin
            w_time_dec[3:0] = 4'd9;
            if (r_time[7:4] != 4'd0) begin
                w_time_dec[7:4] = r_time[7:4] - 4'd1;
            end else begin
                w_time_dec[7:4] = 4'd5;
                if (r_time[11:8] != 4'd0) begin
                    w_time_dec[11:8] = r_time[11:8] - 4'd1;
                end else begin
                    w_time_dec[11:8]  = 4'd9;
                    w_time_dec[15:12] = r_time[15:12] - 4'd1;
                end
            end
        end
    end

    assign w_dec_zero = (w_time_dec == TIME_ZERO);

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------

    // Next state and next time. Stop always wins over start, and a door
    // opening or stop in COOK suppresses any coincident tick.
    always_comb begin
        w_state_next = r_state;
        w_time_next  = r_time;
        case (r_state)
            ST_IDLE: begin
                if (w_stop) begin
                    w_time_next = TIME_ZERO;
                end else if (w_start_event && door_closed && !w_time_zero) begin
                    w_state_next = ST_COOK;
`ifdef QUICK_START_EN
                end else if (w_start_event && door_closed) begin
                    w_state_next = ST_COOK;
                    w_time_next  = TIME_QUICK;
`endif
                end else if (w_key_accept) begin
                    w_time_next = w_time_shift;
                end
            end
            ST_COOK: begin
                if (!door_closed || w_stop) begin
                    w_state_next = ST_PAUSE;
                end else if (tick) begin
                    w_time_next = w_time_dec;
                    if (w_dec_zero) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_stop) begin
                    w_state_next = ST_IDLE;
                    w_time_next  = TIME_ZERO;
                end else if (w_start_event && door_closed) begin
                    w_state_next = ST_COOK;
                end
            end
            ST_DONE: begin
                if (w_stop || !door_closed) begin
                    w_state_next = ST_IDLE;
                    w_time_next  = TIME_ZERO;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_time_next  = TIME_ZERO;
            end
        endcase
    end

    // State register; reset lands in IDLE, which also forces mag_on and done low.
    always_ff @(posedge clk or negedge clearn) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (!clearn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Time digits and input history registers.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_time        <= TIME_ZERO;
            r_keypad_prev <= 10'd0;
            // NOTE: the start history resets to the released level so a button
            // already held through reset does not produce a phantom start.
            r_startn_prev <= 1'b1;
        end else begin
            r_time        <= w_time_next;
            r_keypad_prev <= keypad;
            r_startn_prev <= startn;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------

    assign min_tens = r_time[15:12];
    assign min_ones = r_time[11:8];
    assign sec_tens = r_time[7:4];
    assign sec_ones = r_time[3:0];
    assign state    = r_state;
    assign done     = (r_state == ST_DONE);
    assign mag_on   = (r_state == ST_COOK) && door_closed;

endmodule

// File: tb/tb_mw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mw_sequencer -- self-checking bench for mw_sequencer.
//
// A behavioural model keeps the cook time as two decimal numbers (minutes and
// seconds) and the mode as a plain integer; a compare process checks every DUT
// output against it on each falling clock edge. Directed scenarios pin the
// model with hand-computed literal expectations, then a randomized phase runs.
// Define QUICK_START_EN for both the bench and the RTL to cover that build.
// -----------------------------------------------------------------------------
module tb_mw_sequencer;

    logic       clk = 1'b0;
    logic       clearn = 1'b0;
    logic       tick = 1'b0;
    logic [9:0] keypad = 10'd0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       door_closed = 1'b1;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       mag_on, done;
    logic [1:0] state;

    int n_pass  = 0;
    int n_total = 0;

`ifdef QUICK_START_EN
    localparam bit QUICK = 1'b1;
`else
    localparam bit QUICK = 1'b0;
`endif

    mw_sequencer dut (
        .clk         (clk),
        .clearn      (clearn),
        .tick        (tick),
        .keypad      (keypad),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .mag_on      (mag_on),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: mode 0..3 = IDLE, COOK, PAUSE, DONE; time = mm:ss.
    // ---------------------------------------------------------------------
    int         m_mode = 0;
    int         m_mm   = 0;
    int         m_ss   = 0;
    logic [9:0] m_kprev = 10'd0;
    logic       m_sprev = 1'b1;

    always @(posedge clk or negedge clearn) begin : model
        int  t;
        int  k;
        bit  key_ok;
        bit  start_ev;
        if (!clearn) begin
            m_mode  = 0;
            m_mm    = 0;
            m_ss    = 0;
            m_kprev = 10'd0;
            m_sprev = 1'b1;
        end else begin
            key_ok   = (m_kprev == 10'd0) && ($countones(keypad) == 1);
            k        = 0;
            for (int i = 0; i < 10; i++) if (keypad[i]) k = i;
            start_ev = m_sprev && !startn;
            t        = m_mm * 100 + m_ss;
            case (m_mode)
                0: begin
                    if (!stopn) t = 0;
                    else if (start_ev && door_closed && (t != 0 || QUICK)) begin
                        if (t == 0) t = 30;
                        m_mode = 1;
                    end else if (key_ok) t = (t * 10 + k) % 10000;
                end
                1: begin
                    if (!door_closed || !stopn) m_mode = 2;
                    else if (tick) begin
                        if (t % 100 == 0) t = t - 100 + 59;
                        else t = t - 1;
                        if (t == 0) m_mode = 3;
                    end
                end
                2: begin
                    if (!stopn) begin
                        m_mode = 0;
                        t = 0;
                    end else if (start_ev && door_closed) m_mode = 1;
                end
                default: begin
                    if (!stopn || !door_closed) begin
                        m_mode = 0;
                        t = 0;
                    end
                end
            endcase
            m_mm    = t / 100;
            m_ss    = t % 100;
            m_kprev = keypad;
            m_sprev = startn;
        end
    end

    // Compare process: every output, every cycle.
    always @(negedge clk) begin : compare
        logic [23:0] exp_v;
        exp_v = {2'(m_mode), 4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10),
                 1'(m_mode == 3), 1'(m_mode == 1 && door_closed), 4'd0};
        check("cycle", {state, min_tens, min_ones, sec_tens, sec_ones, done, mag_on, 4'd0}, exp_v);
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ---------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int k);
        keypad = 10'd1 << k;
        cyc();
        keypad = 10'd0;
        cyc();
    endtask

    task automatic start_pulse();
        startn = 1'b0;
        cyc();
        startn = 1'b1;
        cyc();
    endtask

    task automatic stop_pulse();
        stopn = 1'b0;
        cyc();
        stopn = 1'b1;
        cyc();
    endtask

    task automatic check_disp(input string name, input logic [1:0] exp_state, input logic [15:0] exp_time);
        check({name, "_state"}, state, exp_state);
        check({name, "_time"}, {min_tens, min_ones, sec_tens, sec_ones}, exp_time);
    endtask

    initial begin
        int v;
        // Reset
        repeat (3) cyc();
        check_disp("reset", 2'd0, 16'h0000);
        check("reset_done", done, 1'b0);
        check("reset_mag", mag_on, 1'b0);
        clearn = 1'b1;
        cyc();

        // Keys 2,0 -> 00:20, cook 20 ticks to DONE
        press(2);
        press(0);
        check_disp("key20", 2'd0, 16'h0020);
        start_pulse();
        check_disp("start20", 2'd1, 16'h0020);
        for (int i = 1; i <= 20; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (i < 20) begin
                v = 20 - i;
                check("cook_mag", mag_on, 1'b1);
                check_disp("cook20", 2'd1, 16'((v / 10) * 16 + v % 10));
            end
        end
        check_disp("done20", 2'd3, 16'h0000);
        check("done20_flag", done, 1'b1);
        check("done20_mag", mag_on, 1'b0);
        stop_pulse();
        check_disp("done_stop", 2'd0, 16'h0000);

        // 01:00 -> one tick -> 00:59; keys in COOK ignored
        press(1);
        press(0);
        press(0);
        check_disp("key100", 2'd0, 16'h0100);
        start_pulse();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check_disp("borrow", 2'd1, 16'h0059);
        press(7);
        check_disp("cook_key", 2'd1, 16'h0059);
        stop_pulse();
        check_disp("cook_stop", 2'd2, 16'h0059);
        stop_pulse();
        check_disp("pause_stop", 2'd0, 16'h0000);

        // Door opens with a coincident tick -> PAUSE, no decrement; resume
        press(1);
        press(5);
        start_pulse();
        check_disp("start15", 2'd1, 16'h0015);
        door_closed = 1'b0;
        tick = 1'b1;
        #1;
        check("door_mag_drop", mag_on, 1'b0);
        cyc();
        tick = 1'b0;
        check_disp("door_pause", 2'd2, 16'h0015);
        door_closed = 1'b1;
        cyc();
        start_pulse();
        check_disp("resume", 2'd1, 16'h0015);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check_disp("resume_tick", 2'd1, 16'h0014);

        // PAUSE + stop -> IDLE 00:00; stop with start edge in IDLE -> stays IDLE
        door_closed = 1'b0;
        cyc();
        door_closed = 1'b1;
        stopn = 1'b0;
        cyc();
        stopn = 1'b1;
        check_disp("pause_clear", 2'd0, 16'h0000);
        cyc();
        press(3);
        stopn  = 1'b0;
        startn = 1'b0;
        cyc();
        stopn  = 1'b1;
        startn = 1'b1;
        check_disp("stop_start", 2'd0, 16'h0000);
        cyc();

        // Multi-bit key ignored; held start gives a single event
        keypad = 10'b0000000011;
        cyc();
        keypad = 10'd0;
        cyc();
        check_disp("multikey", 2'd0, 16'h0000);
        press(4);
        startn = 1'b0;
        cyc();
        check_disp("held_start", 2'd1, 16'h0004);
        door_closed = 1'b0;
        cyc();
        door_closed = 1'b1;
        repeat (498) cyc();
        check_disp("held_once", 2'd2, 16'h0004);
        startn = 1'b1;
        cyc();
        stop_pulse();

        // Start at 00:00
        start_pulse();
        if (QUICK) check_disp("quick", 2'd1, 16'h0030);
        else       check_disp("quick", 2'd0, 16'h0000);
        stop_pulse();
        stop_pulse();

        // Reset mid-COOK
        press(9);
        start_pulse();
        check("pre_reset_mag", mag_on, 1'b1);
        @(posedge clk);
        #3 clearn = 1'b0;
        #1;
        check("rst_mag", mag_on, 1'b0);
        check_disp("rst_cook", 2'd0, 16'h0000);
        cyc();
        clearn = 1'b1;
        cyc();

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            v = int'($urandom_range(0, 9));
            if (v < 6)      keypad = 10'd0;
            else if (v < 9) keypad = 10'd1 << $urandom_range(0, 9);
            else            keypad = 10'($urandom);
            tick        = ($urandom_range(0, 2) == 0);
            startn      = ($urandom_range(0, 3) != 0);
            stopn       = ($urandom_range(0, 19) != 0);
            door_closed = ($urandom_range(0, 11) != 0);
            clearn      = ($urandom_range(0, 499) != 0);
            cyc();
        end
        clearn = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
